// File: rtl/energy_accum_48.sv
// Block-integrating energy detector: squares complex samples, sums I^2+Q^2
// over 2^N valid samples and dumps one 48-bit block sum with a valid strobe.
module energy_accum_48 #(
   parameter int DATA_WIDTH   = 16,
   parameter int MAX_LOG2_LEN = 16
) (
   input  logic                         clk,
   input  logic                         sync_reset,
   input  logic [4:0]                   acc_len_i,
   input  logic                         valid_i,
   input  logic signed [DATA_WIDTH-1:0] i_sig_i,
   input  logic signed [DATA_WIDTH-1:0] q_sig_i,
   output logic                         valid_o,
   output logic [47:0]                  signal_o
);

   localparam int PROD_W = 2*DATA_WIDTH - 1;
   localparam int PWR_W  = 2*DATA_WIDTH;
   localparam int CNT_W  = MAX_LOG2_LEN;
   localparam int ACC_W  = 48;

   logic [DATA_WIDTH-1:0] abs_i, abs_q;
   logic [PROD_W-1:0]     ii_d, qq_d, ii_r, qq_r;
   logic [PWR_W-1:0]      p_r;
   logic                  v1, v2;
   logic [4:0]            len_r, len_clamp, len_eff;
   logic [CNT_W-1:0]      cnt, term;
   logic [ACC_W-1:0]      acc, p_ext, sum;

   // Squaring the magnitude keeps the product unsigned; |-32768| still fits
   // in DATA_WIDTH unsigned bits, so the product peaks at exactly 2^30.
   // NOTE: every always_comb output gets a default/full assignment so no latch is inferred.
   always_comb begin
      abs_i = i_sig_i[DATA_WIDTH-1] ? (~i_sig_i + 1'b1) : i_sig_i;
      abs_q = q_sig_i[DATA_WIDTH-1] ? (~q_sig_i + 1'b1) : q_sig_i;
      ii_d  = {{(PROD_W-DATA_WIDTH){1'b0}}, abs_i} * {{(PROD_W-DATA_WIDTH){1'b0}}, abs_i};
      qq_d  = {{(PROD_W-DATA_WIDTH){1'b0}}, abs_q} * {{(PROD_W-DATA_WIDTH){1'b0}}, abs_q};
   end

   // The first sample of a block uses the freshly clamped length, later ones the latched copy.
   always_comb begin
      len_clamp = (acc_len_i > 5'(MAX_LOG2_LEN)) ? 5'(MAX_LOG2_LEN) : acc_len_i;
      len_eff   = (cnt == '0) ? len_clamp : len_r;
      term      = ~({CNT_W{1'b1}} << len_eff);
      p_ext     = {{(ACC_W-PWR_W){1'b0}}, p_r};
      sum       = (cnt == '0) ? p_ext : (acc + p_ext);
   end

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         v1       <= 1'b0;
         v2       <= 1'b0;
         ii_r     <= '0;
         qq_r     <= '0;
         p_r      <= '0;
         len_r    <= '0;
         cnt      <= '0;
         acc      <= '0;
         valid_o  <= 1'b0;
         signal_o <= '0;
      end else begin
         v1 <= valid_i;
         if (valid_i) begin
            ii_r <= ii_d;
            qq_r <= qq_d;
         end

         v2  <= v1;
         p_r <= {1'b0, ii_r} + {1'b0, qq_r};

         valid_o <= 1'b0;
         if (v2) begin
            acc <= sum;
            if (cnt == '0)
               len_r <= len_clamp;
            if (cnt == term) begin
               signal_o <= sum;
               valid_o  <= 1'b1;
               cnt      <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/energy_accum_48.md
Name: energy_accum_48

Overview:
Block-integrating energy detector. It sits directly upstream of the 48-to-13 bit slicer stage and produces the 48-bit energy signal that the slicer consumes.
- Computes the instantaneous power I^2+Q^2 of complex 16-bit samples.
- Integrates the power over a runtime-programmable block of 2^N valid samples.
- Dumps one 48-bit sum per block with a single-cycle valid strobe.

Parameters:
- DATA_WIDTH, 16, signed width of each I and Q input component. This spec covers only 16. The 48-bit output headroom holds for DATA_WIDTH=16 and MAX_LOG2_LEN=16.
- MAX_LOG2_LEN, 16, maximum permitted log2 block length. acc_len_i values above this are clamped to it.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- sync_reset  input  1  synchronous, active-high reset.
- acc_len_i  input  5  log2 of integration block length (0..16). Sampled at block start.
- valid_i  input  1  input sample valid.
- i_sig_i  input  16  signed in-phase sample.
- q_sig_i  input  16  signed quadrature sample.
- valid_o  output  1  one-cycle strobe; signal_o holds a new block sum.
- signal_o  output  48  unsigned block energy sum.

Behaviour:
- One clock, clk. sync_reset is synchronous, active-high and has priority over all other logic.
- Reset values:
  - valid_o=0, signal_o=0.
  - Pipeline valids=0, accumulator=0, sample counter=0.
  - Latched length=0 (block of 1).
- Pipeline, 3 stages. Every stage advances every clock; there is no backpressure.
  - S1: when valid_i, register ii=i*i and qq=q*q as 31-bit unsigned products (max 2^30 each). v1<=valid_i.
  - S2: p=ii+qq as 32-bit unsigned (max 2^31). v2<=v1.
  - S3: accumulate/dump on v2.
- Block start: at S3 with v2=1 and cnt==0:
  - Latch len_r=min(acc_len_i, MAX_LOG2_LEN).
  - acc<=p, zero-extended to 48 bits.
  - The clamped length applies to the current block.
- Mid-block: at S3 with v2=1 and cnt!=0, acc<=acc+p.
- Counter: cnt advances only on v2. Terminal count is (2^len_r)-1.
- Terminal sample: at S3 with v2=1 and cnt==terminal:
  - signal_o<=acc+p, or p alone when len_r=0 (cnt==0 is both start and terminal).
  - valid_o<=1 for exactly one cycle.
  - cnt<=0.
- Otherwise valid_o<=0. signal_o holds its last dumped value.
- Latency: valid_o asserts 3 clocks after the clock on which the block's last valid_i sample is presented.
- Gaps: valid_i may deassert for any number of cycles. Gaps do not advance cnt or alter acc. Block sums are identical with or without gaps.
- Length changes: acc_len_i changes mid-block are ignored until the next block start. No partial or early dump occurs.
- Overflow: cannot occur. The maximum sum is 2^31 * 2^16 = 2^47, which is below 2^48. No saturation logic is needed.
- Back-to-back blocks: the dump and the first sample of the next block may occur on consecutive clocks with no lost samples.
- Reset mid-block:
  - The partial sum and counter are discarded.
  - Samples in S1/S2 at reset are dropped.
  - The first valid sample after reset release starts a new block.
- Output contract for the slicer stage: signal_o is stable between valid_o strobes.

Test Plan:
- Basic block: acc_len_i=2, 4 consecutive samples I=1000, Q=1000 -> one valid_o pulse, 3 clocks after the 4th sample, with signal_o=8,000,000. No other pulse.
- Full-scale headroom: acc_len_i=16, 65536 samples I=Q=-32768 -> signal_o=140,737,488,355,328 (2^47). No wrap.
- len=0 and clamp:
  - acc_len_i=0, samples (3,4),(−5,12) -> pulses on consecutive cycles with 25 then 169.
  - acc_len_i=31 -> behaves as 16 (pulse after 65536 samples).
- Gaps and mid-block length change:
  - acc_len_i=1, samples (1,0), 5 idle cycles, then (0,2) -> single sum of 5.
  - Changing acc_len_i to 3 between those two samples does not alter the block. The next block is 8 samples long.
- Reset mid-block:
  - acc_len_i=2, 2 samples of (100,0), sync_reset 1 cycle -> valid_o=0, signal_o=0.
  - Then 4 samples of (1,1) -> signal_o=8. The pre-reset energy is excluded.
- Back-to-back: acc_len_i=1, 6 continuous samples I=Q=1 -> valid_o pulses every 2 clocks, 3 pulses, each with signal_o=4.
